hazard_ctrl_pipe: RTL and testbench

//  Consumer of the ID-stage control bundle: carries it through the ID/EX, EX/MEM and MEM/WB

---
 rtl/hazard_ctrl_pipe.sv | 187 ++++++++++++++++++
 tb/tb_hazard_ctrl_pipe.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_pipe.sv
// Control-side pipeline for a 5-stage MIPS core. It carries the decoded control fields through
// ID/EX, EX/MEM and MEM/WB, and provides load-use stalls, branch squash and forwarding selects.
module hazard_ctrl_pipe #(
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_reg_dst,
  input  logic               id_alu_src,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic               id_branch,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_reg_src,
  input  logic               id_reg_write,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               mem_zero,
  output logic               ex_reg_dst,
  output logic               ex_alu_src,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic [REG_AW-1:0]  ex_rs,
  output logic [REG_AW-1:0]  ex_rt,
  output logic               mem_mem_read,
  output logic               mem_mem_write,
  output logic               mem_branch,
  output logic               wb_reg_src,
  output logic               wb_reg_write,
  output logic [REG_AW-1:0]  wb_dst,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic               pc_write,
  output logic               ifid_write,
  output logic               ifid_flush,
  output logic               pc_src
);

  // ID/EX register
  logic               reg_dst_p0;
  logic               alu_src_p0;
  logic [ALUOP_W-1:0] alu_op_p0;
  logic               branch_p0;
  logic               mem_read_p0;
  logic               mem_write_p0;
  logic               reg_src_p0;
  logic               reg_write_p0;
  logic [REG_AW-1:0]  rs_p0;
  logic [REG_AW-1:0]  rt_p0;
  logic [REG_AW-1:0]  rd_p0;

  // EX/MEM register
  logic               branch_p1;
  logic               mem_read_p1;
  logic               mem_write_p1;
  logic               reg_src_p1;
  logic               reg_write_p1;
  logic [REG_AW-1:0]  dst_p1;

  // MEM/WB register
  logic               reg_src_p2;
  logic               reg_write_p2;
  logic [REG_AW-1:0]  dst_p2;

  logic               taken;
  logic               load_use;
  logic [REG_AW-1:0]  ex_dst;

  // EX/MEM result wins over MEM/WB because it carries the younger write; r0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] src,
    input logic              mem_we,
    input logic [REG_AW-1:0] mem_dst,
    input logic              wb_we,
    input logic [REG_AW-1:0] wb_d
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (mem_we && (mem_dst != '0) && (mem_dst == src))
      sel = 2'b10;
    else if (wb_we && (wb_d != '0) && (wb_d == src))
      sel = 2'b01;
    return sel;
  endfunction

  assign ex_dst   = reg_dst_p0 ? rd_p0 : rt_p0;
  assign taken    = branch_p1 & mem_zero;
  assign load_use = mem_read_p0 & (rt_p0 != '0) & ((rt_p0 == id_rs) | (rt_p0 == id_rt));

  // ID -> EX: bubble on squash or stall, otherwise capture the decoder bundle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_dst_p0   <= 1'b0;
      alu_src_p0   <= 1'b0;
      alu_op_p0    <= '0;
      branch_p0    <= 1'b0;
      mem_read_p0  <= 1'b0;
      mem_write_p0 <= 1'b0;
      reg_src_p0   <= 1'b0;
      reg_write_p0 <= 1'b0;
      rs_p0        <= '0;
      rt_p0        <= '0;
      rd_p0        <= '0;
    end else if (taken || load_use) begin
      reg_dst_p0   <= 1'b0;
      alu_src_p0   <= 1'b0;
      alu_op_p0    <= '0;
      branch_p0    <= 1'b0;
      mem_read_p0  <= 1'b0;
      mem_write_p0 <= 1'b0;
      reg_src_p0   <= 1'b0;
      reg_write_p0 <= 1'b0;
      rs_p0        <= '0;
      rt_p0        <= '0;
      rd_p0        <= '0;
    end else begin
      reg_dst_p0   <= id_reg_dst;
      alu_src_p0   <= id_alu_src;
      alu_op_p0    <= id_alu_op;
      branch_p0    <= id_branch;
      mem_read_p0  <= id_mem_read;
      mem_write_p0 <= id_mem_write;
      reg_src_p0   <= id_reg_src;
      reg_write_p0 <= id_reg_write;
      rs_p0        <= id_rs;
      rt_p0        <= id_rt;
      rd_p0        <= id_rd;
    end
  end

  // EX -> MEM: a taken branch squashes the instruction leaving EX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || taken) begin
      if (!rst_n || taken) begin
        branch_p1    <= 1'b0;
        mem_read_p1  <= 1'b0;
        mem_write_p1 <= 1'b0;
        reg_src_p1   <= 1'b0;
        reg_write_p1 <= 1'b0;
        dst_p1       <= '0;
      end
    end else begin
      branch_p1    <= branch_p0;
      mem_read_p1  <= mem_read_p0;
      mem_write_p1 <= mem_write_p0;
      reg_src_p1   <= reg_src_p0;
      reg_write_p1 <= reg_write_p0;
      dst_p1       <= ex_dst;
    end
  end

  // MEM -> WB: always advances, so the branch itself completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_src_p2   <= 1'b0;
      reg_write_p2 <= 1'b0;
      dst_p2       <= '0;
    end else begin
      reg_src_p2   <= reg_src_p1;
      reg_write_p2 <= reg_write_p1;
      dst_p2       <= dst_p1;
    end
  end

  assign ex_reg_dst    = reg_dst_p0;
  assign ex_alu_src    = alu_src_p0;
  assign ex_alu_op     = alu_op_p0;
  assign ex_rs         = rs_p0;
  assign ex_rt         = rt_p0;
  assign mem_mem_read  = mem_read_p1;
  assign mem_mem_write = mem_write_p1;
  assign mem_branch    = branch_p1;
  assign wb_reg_src    = reg_src_p2;
  assign wb_reg_write  = reg_write_p2;
  assign wb_dst        = dst_p2;

  assign fwd_a = fwd_sel(rs_p0, reg_write_p1, dst_p1, reg_write_p2, dst_p2);
  assign fwd_b = fwd_sel(rt_p0, reg_write_p1, dst_p1, reg_write_p2, dst_p2);

  // A taken branch overrides the stall: the stalled instruction is wrong-path anyway.
  assign pc_src     = taken;
  assign ifid_flush = taken;
  assign pc_write   = taken | ~load_use;
  assign ifid_write = taken | ~load_use;

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Bench for hazard_ctrl_pipe: an instruction-level pipeline model checked every cycle, plus
// directed sequences with hand-computed expectations.
module tb_hazard_ctrl_pipe;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       reg_src;
    logic       reg_write;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } instr_t;

  localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_NOP = 4;
  localparam instr_t BUB = '0;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  instr_t id = '0;
  logic mem_zero = 1'b0;
  logic chk_en = 1'b0;

  logic       ex_reg_dst, ex_alu_src, mem_mem_read, mem_mem_write, mem_branch;
  logic       wb_reg_src, wb_reg_write, pc_write, ifid_write, ifid_flush, pc_src;
  logic [1:0] ex_alu_op, fwd_a, fwd_b;
  logic [4:0] ex_rs, ex_rt, wb_dst;

  int checks = 0;
  int errors = 0;

  // In-flight instructions of the model, one whole instruction per stage
  instr_t m_ex = '0, m_mem = '0, m_wb = '0;

  always #5 clk = ~clk;

  hazard_ctrl_pipe #(.REG_AW(5), .ALUOP_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_reg_dst(id.reg_dst), .id_alu_src(id.alu_src), .id_alu_op(id.alu_op),
    .id_branch(id.branch), .id_mem_read(id.mem_read), .id_mem_write(id.mem_write),
    .id_reg_src(id.reg_src), .id_reg_write(id.reg_write),
    .id_rs(id.rs), .id_rt(id.rt), .id_rd(id.rd),
    .mem_zero(mem_zero),
    .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
    .ex_rs(ex_rs), .ex_rt(ex_rt),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write), .mem_branch(mem_branch),
    .wb_reg_src(wb_reg_src), .wb_reg_write(wb_reg_write), .wb_dst(wb_dst),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .pc_src(pc_src)
  );

  function automatic instr_t mk(input int kind, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd);
    instr_t i;
    i = '0;
    i.rs = rs;
    i.rt = rt;
    i.rd = rd;
    case (kind)
      K_R:   begin i.reg_dst = 1; i.alu_op = 2'd2; i.reg_write = 1; end
      K_LW:  begin i.alu_src = 1; i.mem_read = 1; i.reg_src = 1; i.reg_write = 1; end
      K_SW:  begin i.alu_src = 1; i.mem_write = 1; end
      K_BEQ: begin i.branch = 1; i.alu_op = 2'd1; end
      default: i = '0;
    endcase
    return i;
  endfunction

  function automatic logic [4:0] dest(input instr_t i);
    return i.reg_dst ? i.rd : i.rt;
  endfunction

  function automatic logic m_taken();
    return m_mem.branch && mem_zero;
  endfunction

  function automatic logic m_stall();
    return m_ex.mem_read && (m_ex.rt != 0) && (m_ex.rt == id.rs || m_ex.rt == id.rt);
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] r);
    if (m_mem.reg_write && dest(m_mem) != 0 && dest(m_mem) == r) return 2'b10;
    if (m_wb.reg_write && dest(m_wb) != 0 && dest(m_wb) == r) return 2'b01;
    return 2'b00;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model advance: a whole instruction moves from stage to stage
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ex = BUB; m_mem = BUB; m_wb = BUB;
    end else begin
      logic tk, lu;
      tk = m_taken();
      lu = m_stall();
      m_wb = m_mem;
      if (tk) begin
        m_mem = BUB; m_ex = BUB;
      end else begin
        m_mem = m_ex;
        m_ex  = lu ? BUB : id;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ex_reg_dst", ex_reg_dst, m_ex.reg_dst);
      chk("ex_alu_src", ex_alu_src, m_ex.alu_src);
      chk("ex_alu_op", ex_alu_op, m_ex.alu_op);
      chk("ex_rs", ex_rs, m_ex.rs);
      chk("ex_rt", ex_rt, m_ex.rt);
      chk("mem_mem_read", mem_mem_read, m_mem.mem_read);
      chk("mem_mem_write", mem_mem_write, m_mem.mem_write);
      chk("mem_branch", mem_branch, m_mem.branch);
      chk("wb_reg_src", wb_reg_src, m_wb.reg_src);
      chk("wb_reg_write", wb_reg_write, m_wb.reg_write);
      chk("wb_dst", wb_dst, dest(m_wb));
      chk("fwd_a", fwd_a, m_fwd(m_ex.rs));
      chk("fwd_b", fwd_b, m_fwd(m_ex.rt));
      chk("pc_src", pc_src, m_taken());
      chk("ifid_flush", ifid_flush, m_taken());
      chk("pc_write", pc_write, m_taken() || !m_stall());
      chk("ifid_write", ifid_write, m_taken() || !m_stall());
    end
  end

  task automatic drive(input instr_t i, input logic z);
    @(posedge clk);
    #1;
    id = i;
    mem_zero = z;
    #2;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ex_alu_op"}, ex_alu_op, 0);
    chk({tag, "_ex_reg_dst"}, ex_reg_dst, 0);
    chk({tag, "_mem_read"}, mem_mem_read, 0);
    chk({tag, "_wb_reg_write"}, wb_reg_write, 0);
    chk({tag, "_fwd_a"}, fwd_a, 0);
    chk({tag, "_fwd_b"}, fwd_b, 0);
    chk({tag, "_pc_write"}, pc_write, 1);
    chk({tag, "_ifid_write"}, ifid_write, 1);
    chk({tag, "_pc_src"}, pc_src, 0);
    chk({tag, "_ifid_flush"}, ifid_flush, 0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 chk_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Mid-cycle reset with forwarding in flight
    drive(mk(K_R, 2, 3, 1), 0);
    drive(mk(K_R, 1, 1, 4), 0);
    drive(mk(K_NOP, 0, 0, 0), 0);
    chk("t1_pre_fwd_a", fwd_a, 2'b10);
    chk("t1_pre_reg_dst", ex_reg_dst, 1);
    #1 rst_n = 1'b0;
    #1 chk_idle("t1_midrst");
    chk("t1_ex_rs", ex_rs, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load-use: LW r2,0(r1); ADD r3,r2,r4
    drive(mk(K_LW, 1, 2, 0), 0);
    drive(mk(K_R, 2, 4, 3), 0);
    chk("t2_pc_write", pc_write, 0);
    chk("t2_ifid_write", ifid_write, 0);
    drive(mk(K_R, 2, 4, 3), 0);
    chk("t2_bub_alu_op", ex_alu_op, 0);
    chk("t2_bub_rs", ex_rs, 0);
    chk("t2_resume", pc_write, 1);
    drive(mk(K_NOP, 0, 0, 0), 0);
    chk("t2_ex_rs", ex_rs, 2);
    chk("t2_fwd_a", fwd_a, 2'b01);
    chk("t2_fwd_b", fwd_b, 2'b00);

    // EX/MEM forwarding: ADD r1,r2,r3; SUB r5,r1,r1
    drive(mk(K_R, 2, 3, 1), 0);
    drive(mk(K_R, 1, 1, 5), 0);
    chk("t3_no_stall", pc_write, 1);
    drive(mk(K_NOP, 0, 0, 0), 0);
    chk("t3_fwd_a", fwd_a, 2'b10);
    chk("t3_fwd_b", fwd_b, 2'b10);

    // Younger producer wins
    drive(mk(K_R, 2, 3, 1), 0);
    drive(mk(K_R, 4, 5, 1), 0);
    drive(mk(K_R, 1, 0, 6), 0);
    drive(mk(K_NOP, 0, 0, 0), 0);
    chk("t4_fwd_a", fwd_a, 2'b10);
    chk("t4_fwd_b", fwd_b, 2'b00);

    // Taken branch overrides a simultaneous load-use stall
    drive(mk(K_BEQ, 1, 2, 0), 0);
    drive(mk(K_LW, 1, 7, 0), 0);
    drive(mk(K_R, 7, 0, 3), 1);
    chk("t5_pc_src", pc_src, 1);
    chk("t5_ifid_flush", ifid_flush, 1);
    chk("t5_pc_write", pc_write, 1);
    chk("t5_ifid_write", ifid_write, 1);
    drive(mk(K_NOP, 0, 0, 0), 0);
    chk("t5_ex_alu_src", ex_alu_src, 0);
    chk("t5_ex_alu_op", ex_alu_op, 0);
    chk("t5_mem_read", mem_mem_read, 0);
    chk("t5_mem_branch", mem_branch, 0);
    drive(mk(K_BEQ, 1, 2, 0), 0);
    drive(mk(K_NOP, 0, 0, 0), 0);
    drive(mk(K_NOP, 0, 0, 0), 0);
    chk("t5_nt_branch", mem_branch, 1);
    chk("t5_nt_pc_src", pc_src, 0);
    chk("t5_nt_flush", ifid_flush, 0);

    // r0 destinations neither stall nor forward
    drive(mk(K_LW, 1, 0, 0), 0);
    drive(mk(K_R, 0, 0, 3), 0);
    chk("t6_lw_no_stall", pc_write, 1);
    chk("t6_lw_ifid", ifid_write, 1);
    drive(mk(K_NOP, 0, 0, 0), 0);
    chk("t6_lw_fwd_a", fwd_a, 0);
    chk("t6_lw_fwd_b", fwd_b, 0);
    drive(mk(K_R, 2, 3, 0), 0);
    drive(mk(K_R, 0, 0, 3), 0);
    drive(mk(K_NOP, 0, 0, 0), 0);
    chk("t6_add_fwd_a", fwd_a, 0);
    chk("t6_add_fwd_b", fwd_b, 0);

    // Randomized traffic over a small register set to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      instr_t r;
      @(posedge clk);
      #1;
      if ($urandom_range(0, 1) == 0) r = instr_t'($urandom);
      else r = mk(int'($urandom_range(0, 4)), 5'd0, 5'd0, 5'd0);
      r.rs = 5'($urandom_range(0, 3));
      r.rt = 5'($urandom_range(0, 3));
      r.rd = 5'($urandom_range(0, 3));
      id = r;
      mem_zero = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
